// File: rtl/usb_cmd_pkg.sv
// Shared opcodes, response codes and parser state encoding for the USB command decoder.
package usb_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_PING  = 8'h50;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_DATA_HI,
    S_DATA_LO,
    S_EXEC_WR,
    S_EXEC_RD,
    S_RD_WAIT,
    S_RESP0,
    S_RESP1,
    S_RESP2
  } state_e;

  // States in which the parser takes bytes from the host.
  function automatic logic is_rx_state(input state_e s);
    return (s == S_IDLE) || (s == S_ADDR) || (s == S_DATA_HI) || (s == S_DATA_LO);
  endfunction

endpackage

// File: rtl/usb_cmd_timeout.sv
// Clearable inter-byte counter; expired flags the last allowed cycle of a mid-frame wait.
module usb_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic clk_48mhz,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/usb_cmd_parser.sv
// Decodes framed host bytes into single-cycle register accesses and returns ACK/NAK/read data.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | waiting for an opcode byte
//   ADDR      | waiting for the address byte
//   DATA_HI   | waiting for write data [15:8]
//   DATA_LO   | waiting for write data [7:0]
//   EXEC_WR   | reg_we strobe
//   EXEC_RD   | reg_re strobe
//   RD_WAIT   | capture reg_rdata
//   RESP0     | send ACK or NAK
//   RESP1     | send read data [15:8]
//   RESP2     | send read data [7:0]
module usb_cmd_parser
  import usb_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic        clk_48mhz,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic [7:0]  err_count
);

  state_e      r_state;
  state_e      w_next;
  logic        r_rx_ready;
  logic        r_is_read;
  logic        r_nak;
  logic [7:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [7:0]  r_err;
  logic        w_accept;
  logic        w_bad_op;
  logic        w_err_inc;
  logic        w_expired;
  logic        w_tmr_clear;
  logic        w_tmr_en;
  logic [7:0]  w_tx_data;

  assign w_accept = rx_valid && r_rx_ready;
  assign w_bad_op = (rx_data != OP_WRITE) && (rx_data != OP_READ) && (rx_data != OP_PING);

  assign w_tmr_en    = (r_state == S_ADDR) || (r_state == S_DATA_HI) || (r_state == S_DATA_LO);
  assign w_tmr_clear = w_accept || (w_next == S_IDLE);

  usb_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .clear     (w_tmr_clear),
    .enable    (w_tmr_en),
    .expired   (w_expired)
  );

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rx_ready <= is_rx_state(w_next);
    end
  end

  // An accepted byte always takes priority over an expiring timer.
  always_comb begin
    w_next    = r_state;
    w_err_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next    = ((rx_data == OP_WRITE) || (rx_data == OP_READ)) ? S_ADDR : S_RESP0;
          w_err_inc = w_bad_op;
        end
      end
      S_ADDR: begin
        if (w_accept) begin
          w_next = r_is_read ? S_EXEC_RD : S_DATA_HI;
        end else if (w_expired) begin
          w_next    = S_IDLE;
          w_err_inc = 1'b1;
        end
      end
      S_DATA_HI: begin
        if (w_accept) begin
          w_next = S_DATA_LO;
        end else if (w_expired) begin
          w_next    = S_IDLE;
          w_err_inc = 1'b1;
        end
      end
      S_DATA_LO: begin
        if (w_accept) begin
          w_next = S_EXEC_WR;
        end else if (w_expired) begin
          w_next    = S_IDLE;
          w_err_inc = 1'b1;
        end
      end
      S_EXEC_WR: w_next = S_RESP0;
      S_EXEC_RD: w_next = S_RD_WAIT;
      S_RD_WAIT: w_next = S_RESP0;
      S_RESP0: begin
        if (tx_ready) w_next = r_is_read ? S_RESP1 : S_IDLE;
      end
      S_RESP1: begin
        if (tx_ready) w_next = S_RESP2;
      end
      S_RESP2: begin
        if (tx_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_is_read <= 1'b0;
      r_nak     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= '0;
    end else begin
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            r_is_read <= (rx_data == OP_READ);
            r_nak     <= w_bad_op;
          end
          S_ADDR:    r_addr         <= rx_data;
          S_DATA_HI: r_wdata[15:8]  <= rx_data;
          S_DATA_LO: r_wdata[7:0]   <= rx_data;
          default:   ;
        endcase
      end
      if (r_state == S_RD_WAIT) r_rdata <= reg_rdata;
      if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

  always_comb begin
    w_tx_data = 8'h00;
    case (r_state)
      S_RESP0: w_tx_data = r_nak ? RSP_NAK : RSP_ACK;
      S_RESP1: w_tx_data = r_rdata[15:8];
      S_RESP2: w_tx_data = r_rdata[7:0];
      default: w_tx_data = 8'h00;
    endcase
  end

  assign rx_ready  = r_rx_ready;
  assign tx_data   = w_tx_data;
  assign tx_valid  = (r_state == S_RESP0) || (r_state == S_RESP1) || (r_state == S_RESP2);
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = (r_state == S_EXEC_WR);
  assign reg_re    = (r_state == S_EXEC_RD);
  assign busy      = (r_state != S_IDLE);
  assign err_count = r_err;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Scoreboard bench: frames are issued with expected tx bytes and register accesses queued,
// independent monitors pop and compare what the parser actually produces.
module tb_usb_cmd_parser;
  import usb_cmd_pkg::*;

  localparam int TO = 32;

  logic        clk_48mhz = 1'b0;
  logic        reset_n   = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready  = 1'b0;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata = 16'h0000;
  logic        busy;
  logic [7:0]  err_count;

  usb_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  bit [15:0]   model_mem [256];
  bit [15:0]   slave_mem [256];
  logic [7:0]  tx_q [$];
  logic [23:0] wr_q [$];
  logic [7:0]  rd_q [$];
  int checks = 0;
  int errors = 0;
  int stall_mode = 0;
  int stall_cnt = 0;
  int model_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string s);
    checks++;
    errors++;
    $display("FAIL %s at %0t", s, $time);
  endtask

  // Register-bus slave: read data appears the cycle after reg_re.
  always @(posedge clk_48mhz) begin
    if (reg_we) slave_mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= slave_mem[reg_addr];
  end

  // tx_ready driver: 0 = always ready, 1 = 5-cycle stall per byte, 2 = random
  initial begin
    forever begin
      @(posedge clk_48mhz);
      #1;
      case (stall_mode)
        0: tx_ready = 1'b1;
        1: begin
          if (!tx_valid) begin
            tx_ready = 1'b0;
            stall_cnt = 0;
          end else if (stall_cnt == 5) begin
            tx_ready = 1'b1;
            stall_cnt = 0;
          end else begin
            tx_ready = 1'b0;
            stall_cnt++;
          end
        end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: tx byte scoreboard, hold-stability and register strobe checks.
  initial begin
    forever begin
      @(negedge clk_48mhz);
      if (!reset_n) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready)
          chk("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
        if (tx_valid && tx_ready) begin
          if (tx_q.size() == 0) fail_msg($sformatf("unexpected tx byte %h", tx_data));
          else chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
        end
        if (reg_we) begin
          if (wr_q.size() == 0) fail_msg($sformatf("unexpected reg_we addr %h", reg_addr));
          else chk("reg_write", {8'd0, reg_addr, reg_wdata}, {8'd0, wr_q.pop_front()});
        end
        if (reg_re) begin
          if (rd_q.size() == 0) fail_msg($sformatf("unexpected reg_re addr %h", reg_addr));
          else chk("reg_read_addr", {24'd0, reg_addr}, {24'd0, rd_q.pop_front()});
        end
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk_48mhz);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      @(negedge clk_48mhz);
      n++;
    end
    chk("rx_accept", {31'd0, rx_ready}, 32'd1);
    @(posedge clk_48mhz);
    #1 rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    model_mem[a] = d;
    wr_q.push_back({a, d});
    tx_q.push_back(RSP_ACK);
    send(OP_WRITE); send(a); send(d[15:8]); send(d[7:0]);
  endtask

  task automatic do_read(input logic [7:0] a);
    rd_q.push_back(a);
    tx_q.push_back(RSP_ACK);
    tx_q.push_back(model_mem[a][15:8]);
    tx_q.push_back(model_mem[a][7:0]);
    send(OP_READ); send(a);
  endtask

  task automatic do_ping();
    tx_q.push_back(RSP_ACK);
    send(OP_PING);
  endtask

  task automatic do_bad(input logic [7:0] op);
    tx_q.push_back(RSP_NAK);
    if (model_err < 255) model_err++;
    send(op);
  endtask

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255));
    while (b == OP_WRITE || b == OP_READ || b == OP_PING);
    return b;
  endfunction

  task automatic drain();
    int n = 0;
    while ((tx_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk_48mhz);
      n++;
    end
    chk("drain_pending", tx_q.size() + wr_q.size() + rd_q.size() + 32'(busy), 32'd0);
    repeat (2) @(negedge clk_48mhz);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_48mhz);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_outputs", {tx_valid, tx_data, reg_we, reg_re, busy, err_count},
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
    chk("rst_regs", {8'd0, reg_addr, reg_wdata}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk_48mhz);
    #1;
    chk("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);

    // Directed write and read with stalled response.
    stall_mode = 0;
    do_write(8'h10, 16'hABCD);
    drain();
    chk("wr_addr_hold", {24'd0, reg_addr}, 32'h10);
    chk("wr_data_hold", {16'd0, reg_wdata}, 32'hABCD);
    chk("wr_busy", {31'd0, busy}, 32'd0);
    do_write(8'h22, 16'h1234);
    drain();
    stall_mode = 1;
    do_read(8'h22);
    drain();
    stall_mode = 0;

    // NAK then ping.
    do_bad(8'hFF);
    drain();
    chk("err_after_nak", {24'd0, err_count}, 32'(model_err));
    do_ping();
    drain();

    // Truncated write times out silently.
    send(OP_WRITE);
    send(8'h10);
    repeat (TO + 5) @(negedge clk_48mhz);
    if (model_err < 255) model_err++;
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk("timeout_err", {24'd0, err_count}, 32'(model_err));
    do_read(8'h10);
    drain();

    // Random mixed traffic with random backpressure.
    stall_mode = 2;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: do_write(8'($urandom_range(0, 15)), 16'($urandom));
        1: do_read(8'($urandom_range(0, 15)));
        2: do_ping();
        default: do_bad(rand_bad());
      endcase
    end
    drain();
    chk("rand_err", {24'd0, err_count}, 32'(model_err));

    // Saturation of the error counter.
    stall_mode = 0;
    for (int i = 0; i < 300; i++) do_bad(rand_bad());
    drain();
    chk("err_saturated", {24'd0, err_count}, 32'd255);

    // Reset in the middle of a read response.
    stall_mode = 1;
    do_read(8'h22);
    n = 0;
    while (tx_q.size() != 2 && n < 2000) begin
      @(negedge clk_48mhz);
      n++;
    end
    chk("ack_before_reset", tx_q.size(), 32'd2);
    @(posedge clk_48mhz);
    #2 reset_n = 1'b0;
    #1;
    chk("midrsp_rst_outputs", {tx_valid, tx_data, reg_we, reg_re, busy, err_count},
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
    chk("midrsp_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("midrsp_rst_regs", {8'd0, reg_addr, reg_wdata}, 32'd0);
    tx_q.delete();
    model_err = 0;
    stall_mode = 0;
    repeat (3) @(negedge clk_48mhz);
    reset_n = 1'b1;
    @(posedge clk_48mhz);
    #1;
    chk("rel_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rel_tx_valid", {31'd0, tx_valid}, 32'd0);
    do_ping();
    drain();
    chk("rel_err", {24'd0, err_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
